// File: rtl/data_memory_pkg.sv
// Shared types and access-size constants for the data memory and the load/store stage.
// mask_expand turns a byte-lane mask into a right-justified bit mask.
package data_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [31:0] mask_expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Store-side alignment: legality check, byte enables and lane-shifted write data.
// Purely combinational.
module data_mem_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] wdata_i,
  output logic        legal_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    legal_o = 1'b0;
    unique case (mask_i)
      MASK_BYTE: legal_o = 1'b1;
      MASK_HALF: legal_o = ~offset_i[0];
      MASK_WORD: legal_o = (offset_i == 2'd0);
      default:   legal_o = 1'b0;
    endcase
  end

  assign be_o    = mask_i << offset_i;
  assign wdata_o = wdata_i << {offset_i, 3'b000};

endmodule

// File: rtl/data_memory.sv
// Byte-lane data memory with post-reset clear sequencer; loads return right-justified data
// one cycle after the request and hold until the next load.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data_mem_addr,
  input  logic [31:0] i_data_mem_write_data,
  input  logic        i_data_mem_read_en,
  input  logic        i_data_mem_write_en,
  input  logic [3:0]  i_data_mem_data_mask,
  output logic [31:0] o_data_mem_read_data,
  output logic        o_busy,
  output logic        o_misaligned
);

  logic [31:0] mem_q [DEPTH_WORDS];

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic [1:0]         off;
  logic [INDEX_W-1:0] idx;
  logic               legal;
  logic [3:0]         acc_be;
  logic [31:0]        acc_wdata;

  logic [3:0]         ram_be;
  logic [INDEX_W-1:0] ram_idx;
  logic [31:0]        ram_wdata;
  logic               rd_fire;
  logic               bad_acc;

  logic [31:0]        rd_word_q;
  logic [1:0]         off_q;
  logic [3:0]         mask_q;
  logic               ld_zero_q;
  logic               misaligned_q;

  assign off = i_data_mem_addr[1:0];
  assign idx = i_data_mem_addr[INDEX_W+1:2];

  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, i_data_mem_addr[31:INDEX_W+2]};

  data_mem_align u_align (
    .offset_i (off),
    .mask_i   (i_data_mem_data_mask),
    .wdata_i  (i_data_mem_write_data),
    .legal_o  (legal),
    .be_o     (acc_be),
    .wdata_o  (acc_wdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The clear sequencer owns the RAM write port while busy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_busy    = 1'b0;
    ram_be    = 4'b0000;
    ram_idx   = idx;
    ram_wdata = acc_wdata;
    rd_fire   = 1'b0;
    bad_acc   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        o_busy    = 1'b1;
        ram_be    = 4'b1111;
        ram_idx   = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == INDEX_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (i_data_mem_write_en && legal) ram_be = acc_be;
        rd_fire = i_data_mem_read_en;
        bad_acc = (i_data_mem_read_en | i_data_mem_write_en) & ~legal;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Read-before-write falls out of the nonblocking update.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_be[b]) mem_q[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (rd_fire) rd_word_q <= mem_q[idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      off_q        <= '0;
      mask_q       <= '0;
      ld_zero_q    <= 1'b1;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= bad_acc;
      if (rd_fire) begin
        off_q     <= off;
        mask_q    <= i_data_mem_data_mask;
        ld_zero_q <= ~legal;
      end
    end
  end

  assign o_data_mem_read_data = ld_zero_q ? 32'h0
                              : (rd_word_q >> {off_q, 3'b000}) & mask_expand(mask_q);
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_data_memory.sv
// Randomised and directed check of data_memory against a byte-array reference model.
module tb_data_memory;
  localparam int DEPTH = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_data_mem_addr = '0;
  logic [31:0] i_data_mem_write_data = '0;
  logic        i_data_mem_read_en = 1'b0;
  logic        i_data_mem_write_en = 1'b0;
  logic [3:0]  i_data_mem_data_mask = 4'b1111;
  logic [31:0] o_data_mem_read_data;
  logic        o_busy;
  logic        o_misaligned;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ref_mem [DEPTH][4];
  logic [31:0] exp_rd;

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_data_mem_addr       (i_data_mem_addr),
    .i_data_mem_write_data (i_data_mem_write_data),
    .i_data_mem_read_en    (i_data_mem_read_en),
    .i_data_mem_write_en   (i_data_mem_write_en),
    .i_data_mem_data_mask  (i_data_mem_data_mask),
    .o_data_mem_read_data  (o_data_mem_read_data),
    .o_busy                (o_busy),
    .o_misaligned          (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_bytes(input logic [3:0] m);
    case (m)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One request held for one cycle; results are checked right after its edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
    int n, off, idx;
    bit legal;
    logic [31:0] pre;
    n     = acc_bytes(m);
    off   = int'(a[1:0]);
    idx   = int'((a >> 2) % DEPTH);
    legal = (n != 0) && (off % n == 0);
    pre   = '0;
    if (legal) for (int i = 0; i < n; i++) pre[8*i +: 8] = ref_mem[idx][off+i];
    i_data_mem_read_en    = rd;
    i_data_mem_write_en   = wr;
    i_data_mem_addr       = a;
    i_data_mem_write_data = wd;
    i_data_mem_data_mask  = m;
    step();
    if (rd) exp_rd = legal ? pre : 32'h0;
    if (wr && legal) for (int i = 0; i < n; i++) ref_mem[idx][off+i] = wd[8*i +: 8];
    check_val($sformatf("rdata a=%h m=%b", a, m), o_data_mem_read_data, exp_rd);
    check_val($sformatf("misaligned a=%h m=%b", a, m), {31'b0, o_misaligned},
              {31'b0, (rd | wr) & ~legal});
    check_val("busy_ready", {31'b0, o_busy}, 32'h0);
  endtask

  task automatic idle();
    i_data_mem_read_en  = 1'b0;
    i_data_mem_write_en = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    for (int w = 0; w < DEPTH; w++) for (int b = 0; b < 4; b++) ref_mem[w][b] = 8'h00;
    exp_rd = 32'h0;
    check_val("rst_busy", {31'b0, o_busy}, 32'h1);
    check_val("rst_rdata", o_data_mem_read_data, 32'h0);
    check_val("rst_misaligned", {31'b0, o_misaligned}, 32'h0);
  endtask

  // Counts busy cycles while throwing random (ignored) accesses at the block.
  task automatic wait_clear(input int exp_cycles);
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      i_data_mem_read_en    = 1'($urandom);
      i_data_mem_write_en   = 1'($urandom);
      i_data_mem_addr       = $urandom_range(0, 255);
      i_data_mem_write_data = $urandom;
      i_data_mem_data_mask  = 4'($urandom);
      check_val("clear_misaligned", {31'b0, o_misaligned}, 32'h0);
      check_val("clear_rdata", o_data_mem_read_data, 32'h0);
      n++;
      step();
    end
    idle();
    check_val("clear_len", n, exp_cycles);
  endtask

  function automatic logic [3:0] rand_mask();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'b0001;
    if (r < 6) return 4'b0011;
    if (r < 9) return 4'b1111;
    return 4'($urandom);
  endfunction

  initial begin
    step();
    apply_reset();
    wait_clear(DEPTH);

    for (int a = 0; a < 4*DEPTH; a += 4) access(1, 0, a, 0, 4'b1111);
    check_val("init_word", o_data_mem_read_data, 32'h0);

    access(0, 1, 32'h8, 32'hDEADBEEF, 4'b1111);
    access(1, 0, 32'h8, 0, 4'b0001); check_val("ld_b8", o_data_mem_read_data, 32'hEF);
    access(1, 0, 32'h9, 0, 4'b0001); check_val("ld_b9", o_data_mem_read_data, 32'hBE);
    access(1, 0, 32'hA, 0, 4'b0001); check_val("ld_bA", o_data_mem_read_data, 32'hAD);
    access(1, 0, 32'hB, 0, 4'b0001); check_val("ld_bB", o_data_mem_read_data, 32'hDE);

    access(0, 1, 32'hA, 32'h00001234, 4'b0011);
    access(1, 0, 32'h8, 0, 4'b1111); check_val("ld_w8", o_data_mem_read_data, 32'h1234BEEF);
    access(1, 0, 32'hA, 0, 4'b0011); check_val("ld_hA", o_data_mem_read_data, 32'h00001234);

    access(0, 1, 32'h6, 32'hCAFEF00D, 4'b1111);
    check_val("mis_st", {31'b0, o_misaligned}, 32'h1);
    access(1, 0, 32'h3, 0, 4'b0011);
    check_val("mis_ld_flag", {31'b0, o_misaligned}, 32'h1);
    check_val("mis_ld_data", o_data_mem_read_data, 32'h0);
    access(1, 0, 32'h4, 0, 4'b1111); check_val("mis_unchanged4", o_data_mem_read_data, 32'h0);
    check_val("mis_pulse_end", {31'b0, o_misaligned}, 32'h0);
    access(0, 0, 32'h5, 0, 4'b1111);

    access(0, 1, 32'h4, 32'h11111111, 4'b1111);
    access(1, 1, 32'h4, 32'h55555555, 4'b1111);
    check_val("rbw_old", o_data_mem_read_data, 32'h11111111);
    access(1, 0, 32'h4, 0, 4'b1111); check_val("rbw_new", o_data_mem_read_data, 32'h55555555);
    access(0, 0, 32'h0, 0, 4'b1111); check_val("hold", o_data_mem_read_data, 32'h55555555);

    for (int k = 0; k < 400; k++)
      access(1'($urandom), 1'($urandom), $urandom_range(0, 255), $urandom, rand_mask());

    access(0, 1, 32'h10, 32'hA5A5A5A5, 4'b1111);
    apply_reset();
    repeat (6) step();
    apply_reset();
    wait_clear(DEPTH);
    for (int a = 0; a < 4*DEPTH; a += 4) access(1, 0, a, 0, 4'b1111);
    access(1, 0, 32'h10, 0, 4'b1111); check_val("post_rst_word", o_data_mem_read_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
